cache_fill_arbiter: RTL and testbench
=====================================

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 23, line-address width (byte address bits 25:3).
REQ-002 SHALL have parameter: BURST_LEN, 4, 16-bit words per cacheline fill.
REQ-003 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: c0_req  in  1  requester 0 (instruction cache) fill request; level, held until first c0_fill.
REQ-006 SHALL have port: c0_addr  in  ADDR_W  requester 0 line address.
REQ-007 SHALL have port: c0_fill  out  1  requester 0 word strobe; one pulse per word.
REQ-008 SHALL have ports: c1_req, c1_addr, c1_fill, as c0_* for requester 1 (data cache).
REQ-009 SHALL have port: fill_data  out  16  word delivered with any cN_fill, shared by both requesters.
REQ-010 SHALL have port: sd_req  out  1  burst-read request to SDRAM controller; held until sd_ack.
REQ-011 SHALL have port: sd_addr  out  ADDR_W  line address of the granted requester.
REQ-012 SHALL have port: sd_ack  in  1  one-cycle pulse: controller accepted the command.
REQ-013 SHALL have port: sd_dvalid  in  1  one-cycle strobe per returned word.
REQ-014 SHALL have port: sd_data  in  16  returned word, valid with sd_dvalid.
REQ-015 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port: gnt  out  1  index of requester currently or most recently granted.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAITDATA, BURST.
REQ-018 IDLE: when any cN_req=1, SHALL latch the grant index and its cN_addr into sd_addr, set sd_req=1, and enter ISSUE on the next edge.
REQ-019 Arbitration SHALL be round-robin: if both requests are high in IDLE, grant the index != last_gnt; a single request is granted regardless of last_gnt.
REQ-020 ISSUE: SHALL hold sd_req and sd_addr stable; on sd_ack=1, clear sd_req and enter WAITDATA.
REQ-021 WAITDATA/BURST: each sd_dvalid=1 SHALL register sd_data into fill_data and pulse the granted cN_fill on the following cycle (latency 1); the other cN_fill SHALL stay 0.
REQ-022 A word counter (width clog2(BURST_LEN)+1) SHALL count dvalids; WAITDATA goes to BURST on the first word; after word BURST_LEN is forwarded, the block SHALL return to IDLE and update last_gnt=gnt.
REQ-023 Consecutive sd_dvalid words SHALL produce consecutive cN_fill pulses with no inserted bubbles; any gaps in sd_dvalid are reproduced unchanged.
REQ-024 sd_dvalid in IDLE or ISSUE SHALL be ignored: no cN_fill, no fill_data update.
REQ-025 sd_dvalid and sd_ack in the same ISSUE cycle: ack honoured, word ignored.
REQ-026 A granted requester dropping cN_req before its burst ends SHALL NOT abort the burst; all BURST_LEN fills are still issued.
REQ-027 Requests arriving while busy=1 SHALL wait; the earliest re-arbitration point is the IDLE cycle after the burst, giving at least one idle cycle between bursts.
REQ-028 sd_ack outside ISSUE SHALL be ignored.
REQ-029 gnt and sd_addr SHALL change only on the IDLE->ISSUE transition.

Reset
REQ-030 While reset_n=0, SHALL force state=IDLE, sd_req=0, c0_fill=0, c1_fill=0, busy=0, gnt=0, last_gnt=1, counter=0, fill_data=0, sd_addr=0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst immediately; on release the block SHALL be in IDLE and ignore remaining dvalids.

Verification
REQ-032 c0_req=1, c0_addr=0x12345; sd_ack 3 cycles after sd_req, then 4 consecutive dvalids 0xA000..0xA003 -> sd_addr=0x12345; c0_fill high 4 consecutive cycles, each 1 cycle after its dvalid; fill_data=0xA000..0xA003; c1_fill=0.
REQ-033 c0_req and c1_req both rise in the same cycle after reset -> c0 granted first (last_gnt=1), then c1 on the following IDLE cycle; gnt sequence 0,1.
REQ-034 Both requesters held high continuously across 4 bursts -> grants alternate 0,1,0,1.
REQ-035 reset_n pulsed low after 2 fill words of a c1 burst -> c1_fill=0 and sd_req=0 immediately; remaining 2 dvalids produce no fills; busy=0.
REQ-036 sd_dvalid pulsed in IDLE with no request -> no fill strobe, fill_data unchanged, busy=0.

Source files
------------

// File: rtl/cache_fill_arbiter.sv
// Two-requester cacheline fill arbiter: round-robin grant, one SDRAM burst
// command per grant, and returned words forwarded to the winner one cycle later.
module cache_fill_arbiter #(
   parameter int ADDR_W    = 23,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              c0_req,
   input  logic [ADDR_W-1:0] c0_addr,
   output logic              c0_fill,
   input  logic              c1_req,
   input  logic [ADDR_W-1:0] c1_addr,
   output logic              c1_fill,
   output logic [15:0]       fill_data,
   output logic              sd_req,
   output logic [ADDR_W-1:0] sd_addr,
   input  logic              sd_ack,
   input  logic              sd_dvalid,
   input  logic [15:0]       sd_data,
   output logic              busy,
   output logic              gnt
);

   localparam int CNT_W = $clog2(BURST_LEN) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAITDATA, BURST} state_t;

   state_t            state_q;
   logic              sd_req_q, gnt_q, last_gnt_q, c0_fill_q, c1_fill_q;
   logic [ADDR_W-1:0] sd_addr_q;
   logic [15:0]       fill_data_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              gnt_d;
   logic [ADDR_W-1:0] addr_d;

   // Contention goes to whoever did not win last; a lone request always wins.
   always_comb begin
      gnt_d  = (c0_req && c1_req) ? ~last_gnt_q : c1_req;
      addr_d = gnt_d ? c1_addr : c0_addr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         sd_req_q    <= 1'b0;
         sd_addr_q   <= '0;
         gnt_q       <= 1'b0;
         last_gnt_q  <= 1'b1;
         cnt_q       <= '0;
         fill_data_q <= '0;
         c0_fill_q   <= 1'b0;
         c1_fill_q   <= 1'b0;
      end else begin
         c0_fill_q <= 1'b0;
         c1_fill_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (c0_req || c1_req) begin
                  gnt_q     <= gnt_d;
                  sd_addr_q <= addr_d;
                  sd_req_q  <= 1'b1;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               if (sd_ack) begin
                  sd_req_q <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= WAITDATA;
               end
            end
            WAITDATA, BURST: begin
               if (sd_dvalid) begin
                  fill_data_q <= sd_data;
                  c0_fill_q   <= ~gnt_q;
                  c1_fill_q   <= gnt_q;
                  if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                     cnt_q      <= '0;
                     last_gnt_q <= gnt_q;
                     state_q    <= IDLE;
                  end else begin
                     cnt_q   <= cnt_q + 1'b1;
                     state_q <= BURST;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign c0_fill   = c0_fill_q;
   assign c1_fill   = c1_fill_q;
   assign fill_data = fill_data_q;
   assign sd_req    = sd_req_q;
   assign sd_addr   = sd_addr_q;
   assign gnt       = gnt_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with hand-computed expectations.
module tb_cache_fill_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        c0_req, c1_req, c0_fill, c1_fill;
   logic [22:0] c0_addr, c1_addr, sd_addr;
   logic [15:0] fill_data, sd_data;
   logic        sd_req, sd_ack, sd_dvalid, busy, gnt;

   int n_chk = 0;
   int n_err = 0;
   logic [15:0] last_fd;

   cache_fill_arbiter #(.ADDR_W(23), .BURST_LEN(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .c0_req(c0_req), .c0_addr(c0_addr), .c0_fill(c0_fill),
      .c1_req(c1_req), .c1_addr(c1_addr), .c1_fill(c1_fill),
      .fill_data(fill_data), .sd_req(sd_req), .sd_addr(sd_addr),
      .sd_ack(sd_ack), .sd_dvalid(sd_dvalid), .sd_data(sd_data),
      .busy(busy), .gnt(gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one burst for an already-raised request. noise: dvalid alongside
   // ack in ISSUE; gap: one idle cycle after word 1 with a stray ack.
   task automatic run_burst(input logic exp_gnt, input logic [22:0] exp_addr,
                            input logic [15:0] base, input bit noise, input bit gap);
      int waited = 0;
      while (!sd_req && waited < 20) begin
         step();
         waited++;
      end
      chk("req_seen", {31'd0, sd_req}, 32'd1);
      if (!sd_req) return;
      chk("gnt", {31'd0, gnt}, {31'd0, exp_gnt});
      chk("sd_addr", {9'd0, sd_addr}, {9'd0, exp_addr});
      chk("busy_issue", {31'd0, busy}, 32'd1);
      step();
      step();
      chk("req_held", {31'd0, sd_req}, 32'd1);
      sd_ack = 1'b1;
      if (noise) begin
         sd_dvalid = 1'b1;
         sd_data   = 16'hDEAD;
      end
      step();
      sd_ack    = 1'b0;
      sd_dvalid = 1'b0;
      chk("req_clr", {31'd0, sd_req}, 32'd0);
      if (noise) begin
         chk("noise_fill", {30'd0, c1_fill, c0_fill}, 32'd0);
         chk("noise_fd", {16'd0, fill_data}, {16'd0, last_fd});
      end
      for (int k = 0; k < 4; k++) begin
         sd_dvalid = 1'b1;
         sd_data   = base + 16'(k);
         step();
         sd_dvalid = 1'b0;
         chk("fill", {30'd0, c1_fill, c0_fill}, exp_gnt ? 32'd2 : 32'd1);
         chk("fill_data", {16'd0, fill_data}, {16'd0, base + 16'(k)});
         if (gap && k == 1) begin
            sd_ack = 1'b1;
            step();
            sd_ack = 1'b0;
            chk("gap_fill", {30'd0, c1_fill, c0_fill}, 32'd0);
            chk("gap_sdreq", {31'd0, sd_req}, 32'd0);
         end
      end
      chk("busy_end", {31'd0, busy}, 32'd0);
      last_fd = base + 16'd3;
   endtask

   initial begin
      reset_n = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
      c0_addr = '0; c1_addr = '0;
      sd_ack = 1'b0; sd_dvalid = 1'b0; sd_data = '0;
      last_fd = '0;
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("rst_sdreq", {31'd0, sd_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_gnt", {31'd0, gnt}, 32'd0);
      chk("rst_fill", {30'd0, c1_fill, c0_fill}, 32'd0);
      chk("rst_fd", {16'd0, fill_data}, 32'd0);
      chk("rst_addr", {9'd0, sd_addr}, 32'd0);

      // single c0 fill, plus dvalid-with-ack noise and a gap
      c0_req = 1'b1; c0_addr = 23'h12345;
      step();
      c0_req = 1'b0;
      run_burst(1'b0, 23'h12345, 16'hA000, 1'b1, 1'b1);

      // dvalid while idle
      sd_dvalid = 1'b1; sd_data = 16'hBEEF;
      step();
      sd_dvalid = 1'b0;
      step();
      chk("idle_fill", {30'd0, c1_fill, c0_fill}, 32'd0);
      chk("idle_fd", {16'd0, fill_data}, 32'h0000A003);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // fresh reset, then both requesting continuously: 0,1,0,1
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      last_fd = '0;
      c0_addr = 23'h00100; c1_addr = 23'h7FFFFF;
      c0_req = 1'b1; c1_req = 1'b1;
      run_burst(1'b0, 23'h00100, 16'h1000, 1'b0, 1'b0);
      run_burst(1'b1, 23'h7FFFFF, 16'h2000, 1'b0, 1'b0);
      run_burst(1'b0, 23'h00100, 16'h3000, 1'b0, 1'b0);
      run_burst(1'b1, 23'h7FFFFF, 16'h4000, 1'b0, 1'b0);
      c0_req = 1'b0; c1_req = 1'b0;
      step();
      chk("after_rr_busy", {31'd0, busy}, 32'd0);

      // c1 burst interrupted by reset after two words
      c1_req = 1'b1; c1_addr = 23'h0ABCD;
      step();
      chk("c1_gnt", {31'd0, gnt}, 32'd1);
      sd_ack = 1'b1;
      step();
      sd_ack = 1'b0;
      c1_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         sd_dvalid = 1'b1; sd_data = 16'hC000 + 16'(k);
         step();
         sd_dvalid = 1'b0;
         chk("pre_rst_fill", {30'd0, c1_fill, c0_fill}, 32'd2);
      end
      reset_n = 1'b0;
      #1;
      chk("rst_mid_fill", {30'd0, c1_fill, c0_fill}, 32'd0);
      chk("rst_mid_sdreq", {31'd0, sd_req}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      step();
      reset_n = 1'b1;
      for (int k = 2; k < 4; k++) begin
         sd_dvalid = 1'b1; sd_data = 16'hC000 + 16'(k);
         step();
         sd_dvalid = 1'b0;
         chk("post_rst_fill", {30'd0, c1_fill, c0_fill}, 32'd0);
         chk("post_rst_fd", {16'd0, fill_data}, 32'd0);
         chk("post_rst_busy", {31'd0, busy}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
